// File: rtl/life_grid.sv
// Conway Game-of-Life engine: full ROWS x COLS board in registers, B3/S23 rule evaluated
// for every cell in parallel, row-wise loading, single-step or free-run at a fixed rate.
module life_grid #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int WRAP   = 1,
    parameter int PERIOD = 1,
    parameter int GEN_W  = 16
) (
    input  logic                    clock,
    input  logic                    freset,
    input  logic                    clear,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [$clog2(ROWS)-1:0] load_row,
    input  logic [COLS-1:0]         load_data,
    input  logic                    step,
    input  logic                    run,
    output logic                    busy,
    output logic [ROWS*COLS-1:0]    grid_out,
    output logic [GEN_W-1:0]        gen_count,
    output logic                    stable,
    output logic                    extinct
);

    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int DW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [N-1:0]     grid_q, grid_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic             stable_q, stable_d;

    logic [N-1:0]     next_grid;
    logic [N-1:0]     load_grid;
    logic [ROWS-1:0]  wr_row;
    logic             load_fire;
    logic             load_ok;
    logic             tick_due;
    logic             do_tick;

    // Neighbour k: 0..2 row above, 3/4 same row left/right, 5..7 row below.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [7:0] nbr;
            logic [3:0] n;
            for (genvar k = 0; k < 8; k++) begin : g_nbr
                localparam int DR = (k < 3) ? -1 : ((k < 5) ? 0 : 1);
                localparam int DC = (k < 3) ? k - 1 : ((k == 3) ? -1 : ((k == 4) ? 1 : k - 6));
                localparam int RR = r + DR;
                localparam int CC = c + DC;
                localparam bit INSIDE = (RR >= 0) && (RR < ROWS) && (CC >= 0) && (CC < COLS);
                localparam bit USE = (WRAP != 0) || INSIDE;
                localparam int IDX = ((RR + ROWS) % ROWS) * COLS + ((CC + COLS) % COLS);
                assign nbr[k] = USE ? grid_q[IDX] : 1'b0;
            end
            assign n = 4'($countones(nbr));
            assign next_grid[r*COLS+c] = (n == 4'd3) | (grid_q[r*COLS+c] & (n == 4'd2));
        end
        assign wr_row[r] = load_fire & load_ok & (load_row == RW'(r));
        assign load_grid[r*COLS +: COLS] = wr_row[r] ? load_data : grid_q[r*COLS +: COLS];
    end

    assign load_ready = (state_q != StRun);
    assign load_fire  = load_valid & load_ready;
    assign load_ok    = ({1'b0, load_row} < (RW + 1)'(ROWS));
    assign tick_due   = (div_q == DW'(PERIOD - 1));

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        grid_d   = grid_q;
        gen_d    = gen_q;
        stable_d = stable_q;
        do_tick  = 1'b0;
        if (clear) begin
            state_d  = StIdle;
            div_d    = '0;
            grid_d   = '0;
            gen_d    = '0;
            stable_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (run) begin
                        state_d = StRun;
                        div_d   = '0;
                    end else if (step && !load_fire) begin
                        do_tick = 1'b1;
                    end
                end
                StRun: begin
                    div_d   = tick_due ? '0 : div_q + 1'b1;
                    do_tick = tick_due;
                    if (!run) state_d = StIdle;
                end
                StHalt: begin
                    if (!run) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase

            if (load_fire) begin
                grid_d   = load_grid;
                stable_d = 1'b0;
            end else if (do_tick) begin
                if (next_grid == grid_q) begin
                    stable_d = 1'b1;
                    // Dropping run in the same cycle returns to IDLE rather than HALT.
                    if (state_q == StRun && run) state_d = StHalt;
                end else begin
                    grid_d   = next_grid;
                    gen_d    = (&gen_q) ? gen_q : gen_q + 1'b1;
                    stable_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge freset) begin
        if (!freset) begin
            state_q  <= StIdle;
            div_q    <= '0;
            grid_q   <= '0;
            gen_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            grid_q   <= grid_d;
            gen_q    <= gen_d;
            stable_q <= stable_d;
        end
    end

    assign busy      = (state_q == StRun);
    assign grid_out  = grid_q;
    assign gen_count = gen_q;
    assign stable    = stable_q;
    assign extinct   = ~|grid_q;

endmodule

// File: tb/tb_life_grid.sv
// Directed bench for life_grid: an 8x8 torus instance (A) and a 6x5 bounded, PERIOD=3,
// 4-bit counter instance (B), checked with immediate assertions against hand-derived boards.
module tb_life_grid;

    logic clock = 1'b0;
    logic freset = 1'b1;
    always #5 clock = ~clock;

    // Instance A: 8x8, WRAP=1, PERIOD=1, GEN_W=16
    logic        a_clear = 0, a_load_valid = 0, a_step = 0, a_run = 0;
    logic [2:0]  a_load_row = '0;
    logic [7:0]  a_load_data = '0;
    logic        a_load_ready, a_busy, a_stable, a_extinct;
    logic [63:0] a_grid;
    logic [15:0] a_gen;

    // Instance B: 6 rows x 5 cols, WRAP=0, PERIOD=3, GEN_W=4
    logic        b_clear = 0, b_load_valid = 0, b_step = 0, b_run = 0;
    logic [2:0]  b_load_row = '0;
    logic [4:0]  b_load_data = '0;
    logic        b_load_ready, b_busy, b_stable, b_extinct;
    logic [29:0] b_grid;
    logic [3:0]  b_gen;

    int n_checks = 0;
    int n_pass   = 0;

    life_grid #(.ROWS(8), .COLS(8), .WRAP(1), .PERIOD(1), .GEN_W(16)) u_a (
        .clock(clock), .freset(freset), .clear(a_clear), .load_valid(a_load_valid),
        .load_ready(a_load_ready), .load_row(a_load_row), .load_data(a_load_data),
        .step(a_step), .run(a_run), .busy(a_busy), .grid_out(a_grid), .gen_count(a_gen),
        .stable(a_stable), .extinct(a_extinct)
    );

    life_grid #(.ROWS(6), .COLS(5), .WRAP(0), .PERIOD(3), .GEN_W(4)) u_b (
        .clock(clock), .freset(freset), .clear(b_clear), .load_valid(b_load_valid),
        .load_ready(b_load_ready), .load_row(b_load_row), .load_data(b_load_data),
        .step(b_step), .run(b_run), .busy(b_busy), .grid_out(b_grid), .gen_count(b_gen),
        .stable(b_stable), .extinct(b_extinct)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    localparam logic [63:0] HORIZ  = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] VERT   = 64'h0000_0008_0808_0000;
    localparam logic [63:0] GLIDER = 64'h0000_0000_0007_0402;
    localparam logic [63:0] B_VERT = 64'h21080;
    localparam logic [63:0] B_HOR  = 64'h3800;

    initial begin
        #2 freset = 1'b0;
        #1;
        chk("rst_grid", a_grid, 0);
        chk("rst_gen", a_gen, 0);
        chk("rst_ready", a_load_ready, 1);
        chk("rst_busy", a_busy, 0);
        chk("rst_extinct", a_extinct, 1);
        chk("rst_stable", a_stable, 0);
        #9 freset = 1'b1;
        cyc();

        // Blinker on A
        a_load_valid = 1; a_load_row = 3'd3; a_load_data = 8'b0001_1100;
        cyc();
        a_load_valid = 0;
        chk("blk_load", a_grid, HORIZ);
        chk("blk_extinct", a_extinct, 0);
        a_run = 1;
        cyc();
        chk("blk_busy", a_busy, 1);
        chk("blk_gen0", a_gen, 0);
        cyc();
        chk("blk_g1", a_grid, VERT);
        cyc();
        chk("blk_g2", a_grid, HORIZ);
        cyc();
        chk("blk_g3", a_grid, VERT);
        a_run = 0;
        cyc();
        chk("blk_g4", a_grid, HORIZ);
        chk("blk_gen4", a_gen, 4);
        chk("blk_idle", a_busy, 0);

        // Asynchronous reset in the middle of RUN
        a_run = 1;
        cyc();
        cyc();
        chk("mid_gen5", a_gen, 5);
        chk("mid_busy", a_busy, 1);
        #1 freset = 1'b0;
        #1;
        chk("arst_grid", a_grid, 0);
        chk("arst_gen", a_gen, 0);
        chk("arst_busy", a_busy, 0);
        chk("arst_ready", a_load_ready, 1);
        a_run = 0;
        #2 freset = 1'b1;
        cyc();

        // Glider returns home after 32 generations on the 8x8 torus
        a_load_valid = 1;
        a_load_row = 3'd0; a_load_data = 8'b0000_0010; cyc();
        a_load_row = 3'd1; a_load_data = 8'b0000_0100; cyc();
        a_load_row = 3'd2; a_load_data = 8'b0000_0111; cyc();
        a_load_valid = 0;
        chk("gl_load", a_grid, GLIDER);
        a_run = 1;
        cyc();
        repeat (31) cyc();
        a_run = 0;
        cyc();
        chk("gl_grid", a_grid, GLIDER);
        chk("gl_gen", a_gen, 32);
        chk("gl_stable", a_stable, 0);
        chk("gl_busy", a_busy, 0);

        // Still life on B: 2x2 block, halts on the first tick (every 3rd RUN cycle)
        b_load_valid = 1; b_load_data = 5'b00011;
        b_load_row = 3'd0; cyc();
        b_load_row = 3'd1; cyc();
        b_load_valid = 0;
        chk("blk2_load", b_grid, 64'h63);
        b_run = 1;
        cyc();
        chk("sl_busy", b_busy, 1);
        cyc();
        cyc();
        chk("sl_pre_stable", b_stable, 0);
        chk("sl_pre_busy", b_busy, 1);
        cyc();
        chk("sl_stable", b_stable, 1);
        chk("sl_halt", b_busy, 0);
        chk("sl_gen", b_gen, 0);
        chk("sl_grid", b_grid, 64'h63);
        chk("sl_ready", b_load_ready, 1);
        b_run = 0;
        cyc();
        b_clear = 1;
        cyc();
        b_clear = 0;
        chk("clr_grid", b_grid, 0);
        chk("clr_stable", b_stable, 0);

        // Load with coincident step, out-of-range row
        b_load_valid = 1; b_load_data = 5'b00100;
        b_load_row = 3'd1; cyc();
        b_load_row = 3'd2; cyc();
        b_load_row = 3'd3; b_step = 1; cyc();
        b_step = 0;
        chk("ls_grid", b_grid, B_VERT);
        chk("ls_gen", b_gen, 0);
        chk("ls_stable", b_stable, 0);
        b_load_row = 3'd6; b_load_data = 5'b11111;
        chk("oor_ready", b_load_ready, 1);
        cyc();
        b_load_valid = 0;
        chk("oor_grid", b_grid, B_VERT);

        b_step = 1; cyc(); b_step = 0;
        chk("step_grid", b_grid, B_HOR);
        chk("step_gen", b_gen, 1);

        // PERIOD=3 pacing, loads and steps blocked during RUN
        b_run = 1;
        cyc();
        b_load_valid = 1; b_load_row = 3'd0; b_load_data = 5'b11111; b_step = 1;
        chk("run_ready", b_load_ready, 0);
        cyc();
        chk("rate_c1", b_grid, B_HOR);
        cyc();
        chk("rate_c2", b_grid, B_HOR);
        chk("rate_gen1", b_gen, 1);
        b_load_valid = 0; b_step = 0;
        cyc();
        chk("rate_tick", b_grid, B_VERT);
        chk("rate_gen2", b_gen, 2);
        cyc();
        cyc();
        b_run = 0;
        cyc();
        chk("stop_tick", b_grid, B_HOR);
        chk("stop_gen", b_gen, 3);
        chk("stop_busy", b_busy, 0);

        // Generation counter saturation
        b_step = 1;
        repeat (20) cyc();
        b_step = 0;
        chk("sat_gen", b_gen, 4'hF);
        chk("sat_grid", b_grid, B_HOR);

        // Lone cell dies
        b_clear = 1; cyc(); b_clear = 0;
        b_load_valid = 1; b_load_row = 3'd2; b_load_data = 5'b00100; cyc();
        b_load_valid = 0;
        chk("lone_alive", b_extinct, 0);
        b_step = 1; cyc(); b_step = 0;
        chk("lone_extinct", b_extinct, 1);
        chk("lone_grid", b_grid, 0);
        chk("lone_gen", b_gen, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
